// File: rtl/alu_operand_stage_pkg.sv
// Shared CPU encodings: operand-select codes and ALU operation codes used by
// the decode, operand and execute stages.
package cpu;

    localparam int OP_SEL_WIDTH  = 2;
    localparam int ALU_SEL_WIDTH = 4;

    // Operand A source select
    localparam logic [OP_SEL_WIDTH-1:0] OP_A_RS1  = 2'd0;
    localparam logic [OP_SEL_WIDTH-1:0] OP_A_PC   = 2'd1;
    localparam logic [OP_SEL_WIDTH-1:0] OP_A_ZERO = 2'd2;

    // Operand B source select
    localparam logic [OP_SEL_WIDTH-1:0] OP_B_RS2  = 2'd0;
    localparam logic [OP_SEL_WIDTH-1:0] OP_B_IMM  = 2'd1;
    localparam logic [OP_SEL_WIDTH-1:0] OP_B_FOUR = 2'd2;

    // ALU operation codes
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_OP_ADD     = 4'd0;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_OP_SUB     = 4'd1;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_OP_SLL     = 4'd2;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_OP_SLT     = 4'd3;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_OP_SLTU    = 4'd4;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_OP_XOR     = 4'd5;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_OP_SRL     = 4'd6;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_OP_SRA     = 4'd7;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_OP_OR      = 4'd8;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_OP_AND     = 4'd9;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_OP_PASS_B  = 4'd10;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_OP_UNKNOWN = 4'd15;

endpackage

// File: rtl/alu_operand_stage_operand_forward_mux.sv
// Resolves one source register value: x0 reads as zero, otherwise the youngest
// in-flight producer (EX/MEM, then MEM/WB) wins over the register file.
module operand_forward_mux #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] i_Addr,
    input  logic [XLEN-1:0]           i_Rf_Data,
    input  logic                      i_Ex_Valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_Ex_Rd,
    input  logic [XLEN-1:0]           i_Ex_Data,
    input  logic                      i_Wb_Valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_Wb_Rd,
    input  logic [XLEN-1:0]           i_Wb_Data,
    output logic [XLEN-1:0]           o_Data
);

    logic ex_hit;
    logic wb_hit;

    assign ex_hit = i_Ex_Valid && (i_Ex_Rd == i_Addr);
    assign wb_hit = i_Wb_Valid && (i_Wb_Rd == i_Addr);

    always_comb begin
        if (i_Addr == '0) begin
            o_Data = '0;
        end else if (ex_hit) begin
            o_Data = i_Ex_Data;
        end else if (wb_hit) begin
            o_Data = i_Wb_Data;
        end else begin
            o_Data = i_Rf_Data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX stage: forwards source operands, registers ALU inputs with a
// valid/ready handshake, and keeps held operands fresh by snooping writeback.
module alu_operand_stage
    import cpu::*;
#(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset_N,
    input  logic                      i_Flush,

    input  logic                      i_Valid,
    output logic                      o_Ready,
    input  logic [XLEN-1:0]           i_Pc,
    input  logic [REG_ADDR_WIDTH-1:0] i_Rs1_Addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_Rs2_Addr,
    input  logic [XLEN-1:0]           i_Rs1_Data,
    input  logic [XLEN-1:0]           i_Rs2_Data,
    input  logic [XLEN-1:0]           i_Immediate,
    input  logic [1:0]                i_Op_A_Sel,
    input  logic [1:0]                i_Op_B_Sel,
    input  logic [3:0]                i_Alu_Select,
    input  logic [REG_ADDR_WIDTH-1:0] i_Rd_Addr,
    input  logic                      i_Reg_Write,

    input  logic                      i_Fwd_Ex_Valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_Fwd_Ex_Rd,
    input  logic [XLEN-1:0]           i_Fwd_Ex_Data,
    input  logic                      i_Fwd_Wb_Valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_Fwd_Wb_Rd,
    input  logic [XLEN-1:0]           i_Fwd_Wb_Data,

    output logic                      o_Valid,
    input  logic                      i_Ready,
    output logic [XLEN-1:0]           o_Input_A,
    output logic [XLEN-1:0]           o_Input_B,
    output logic [3:0]                o_Alu_Select,
    output logic [XLEN-1:0]           o_Store_Data,
    output logic [XLEN-1:0]           o_Pc,
    output logic [REG_ADDR_WIDTH-1:0] o_Rd_Addr,
    output logic                      o_Reg_Write
);

    logic                      valid_q,      valid_d;
    logic [XLEN-1:0]           input_a_q,    input_a_d;
    logic [XLEN-1:0]           input_b_q,    input_b_d;
    logic [XLEN-1:0]           store_data_q, store_data_d;
    logic [XLEN-1:0]           pc_q,         pc_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q,    rd_addr_d;
    logic                      reg_write_q,  reg_write_d;
    logic [3:0]                alu_sel_q,    alu_sel_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_q,   rs1_addr_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_q,   rs2_addr_d;
    logic [1:0]                op_a_sel_q,   op_a_sel_d;
    logic [1:0]                op_b_sel_q,   op_b_sel_d;

    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic            capture;
    logic            stall;
    logic            snoop_rs1;
    logic            snoop_rs2;

    function automatic logic [XLEN-1:0] select_a(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rs1,
        input logic [XLEN-1:0] pc
    );
        case (sel)
            OP_A_RS1: return rs1;
            OP_A_PC:  return pc;
            default:  return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] select_b(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rs2,
        input logic [XLEN-1:0] imm
    );
        case (sel)
            OP_B_RS2:  return rs2;
            OP_B_IMM:  return imm;
            OP_B_FOUR: return XLEN'(4);
            default:   return '0;
        endcase
    endfunction

    operand_forward_mux #(
        .XLEN           (XLEN),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_rs1_fwd (
        .i_Addr     (i_Rs1_Addr),
        .i_Rf_Data  (i_Rs1_Data),
        .i_Ex_Valid (i_Fwd_Ex_Valid),
        .i_Ex_Rd    (i_Fwd_Ex_Rd),
        .i_Ex_Data  (i_Fwd_Ex_Data),
        .i_Wb_Valid (i_Fwd_Wb_Valid),
        .i_Wb_Rd    (i_Fwd_Wb_Rd),
        .i_Wb_Data  (i_Fwd_Wb_Data),
        .o_Data     (rs1_value)
    );

    operand_forward_mux #(
        .XLEN           (XLEN),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_rs2_fwd (
        .i_Addr     (i_Rs2_Addr),
        .i_Rf_Data  (i_Rs2_Data),
        .i_Ex_Valid (i_Fwd_Ex_Valid),
        .i_Ex_Rd    (i_Fwd_Ex_Rd),
        .i_Ex_Data  (i_Fwd_Ex_Data),
        .i_Wb_Valid (i_Fwd_Wb_Valid),
        .i_Wb_Rd    (i_Fwd_Wb_Rd),
        .i_Wb_Data  (i_Fwd_Wb_Data),
        .o_Data     (rs2_value)
    );

    assign o_Ready = !valid_q || i_Ready;
    assign capture = i_Valid && o_Ready && !i_Flush;
    assign stall   = valid_q && !i_Ready;

    // Only WB can update a held operand: an EX result seen during a stall
    // will itself pass through WB before this instruction executes.
    assign snoop_rs1 = stall && i_Fwd_Wb_Valid && (rs1_addr_q != '0)
                     && (i_Fwd_Wb_Rd == rs1_addr_q);
    assign snoop_rs2 = stall && i_Fwd_Wb_Valid && (rs2_addr_q != '0)
                     && (i_Fwd_Wb_Rd == rs2_addr_q);

    always_comb begin
        // NOTE: every next-state signal defaults to its held value first, so no
        // path through this block can leave one unassigned and infer a latch.
        valid_d      = valid_q;
        input_a_d    = input_a_q;
        input_b_d    = input_b_q;
        store_data_d = store_data_q;
        pc_d         = pc_q;
        rd_addr_d    = rd_addr_q;
        reg_write_d  = reg_write_q;
        alu_sel_d    = alu_sel_q;
        rs1_addr_d   = rs1_addr_q;
        rs2_addr_d   = rs2_addr_q;
        op_a_sel_d   = op_a_sel_q;
        op_b_sel_d   = op_b_sel_q;

        if (i_Flush) begin
            valid_d = 1'b0;
        end else if (o_Ready) begin
            valid_d = i_Valid;
        end

        if (capture) begin
            input_a_d    = select_a(i_Op_A_Sel, rs1_value, i_Pc);
            input_b_d    = select_b(i_Op_B_Sel, rs2_value, i_Immediate);
            store_data_d = rs2_value;
            pc_d         = i_Pc;
            rd_addr_d    = i_Rd_Addr;
            reg_write_d  = i_Reg_Write;
            alu_sel_d    = i_Alu_Select;
            rs1_addr_d   = i_Rs1_Addr;
            rs2_addr_d   = i_Rs2_Addr;
            op_a_sel_d   = i_Op_A_Sel;
            op_b_sel_d   = i_Op_B_Sel;
        end else begin
            if (snoop_rs1 && (op_a_sel_q == OP_A_RS1)) begin
                input_a_d = i_Fwd_Wb_Data;
            end
            if (snoop_rs2) begin
                store_data_d = i_Fwd_Wb_Data;
                if (op_b_sel_q == OP_B_RS2) begin
                    input_b_d = i_Fwd_Wb_Data;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            valid_q      <= 1'b0;
            input_a_q    <= '0;
            input_b_q    <= '0;
            store_data_q <= '0;
            pc_q         <= '0;
            rd_addr_q    <= '0;
            reg_write_q  <= 1'b0;
            alu_sel_q    <= ALU_OP_UNKNOWN;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            op_a_sel_q   <= '0;
            op_b_sel_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            input_a_q    <= input_a_d;
            input_b_q    <= input_b_d;
            store_data_q <= store_data_d;
            pc_q         <= pc_d;
            rd_addr_q    <= rd_addr_d;
            reg_write_q  <= reg_write_d;
            alu_sel_q    <= alu_sel_d;
            rs1_addr_q   <= rs1_addr_d;
            rs2_addr_q   <= rs2_addr_d;
            op_a_sel_q   <= op_a_sel_d;
            op_b_sel_q   <= op_b_sel_d;
        end
    end

    assign o_Valid      = valid_q;
    assign o_Input_A    = input_a_q;
    assign o_Input_B    = input_b_q;
    assign o_Store_Data = store_data_q;
    assign o_Pc         = pc_q;
    assign o_Rd_Addr    = rd_addr_q;
    assign o_Reg_Write  = reg_write_q;
    assign o_Alu_Select = alu_sel_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus a random
// stream compared against a behavioural model of the stage.
module tb_alu_operand_stage;
    import cpu::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] pc;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [1:0]  a_sel, b_sel;
    logic [3:0]  alu_sel;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        ex_valid, wb_valid;
    logic [4:0]  ex_rd, wb_rd;
    logic [31:0] ex_data, wb_data;
    logic        out_valid;
    logic        down_ready;
    logic [31:0] op_a, op_b, store_data, out_pc;
    logic [3:0]  out_alu;
    logic [4:0]  out_rd;
    logic        out_rw;

    int checks = 0;
    int errors = 0;

    // Behavioural model: the instruction currently presented to the ALU.
    logic        m_valid;
    logic [31:0] m_a, m_b, m_st, m_pc;
    logic [3:0]  m_alu;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic        m_rw;
    logic [1:0]  m_asel, m_bsel;

    always #5 clk = ~clk;

    alu_operand_stage #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
        .i_Clock        (clk),
        .i_Reset_N      (rst_n),
        .i_Flush        (flush),
        .i_Valid        (in_valid),
        .o_Ready        (out_ready),
        .i_Pc           (pc),
        .i_Rs1_Addr     (rs1_addr),
        .i_Rs2_Addr     (rs2_addr),
        .i_Rs1_Data     (rs1_data),
        .i_Rs2_Data     (rs2_data),
        .i_Immediate    (imm),
        .i_Op_A_Sel     (a_sel),
        .i_Op_B_Sel     (b_sel),
        .i_Alu_Select   (alu_sel),
        .i_Rd_Addr      (rd_addr),
        .i_Reg_Write    (reg_write),
        .i_Fwd_Ex_Valid (ex_valid),
        .i_Fwd_Ex_Rd    (ex_rd),
        .i_Fwd_Ex_Data  (ex_data),
        .i_Fwd_Wb_Valid (wb_valid),
        .i_Fwd_Wb_Rd    (wb_rd),
        .i_Fwd_Wb_Data  (wb_data),
        .o_Valid        (out_valid),
        .i_Ready        (down_ready),
        .o_Input_A      (op_a),
        .o_Input_B      (op_b),
        .o_Alu_Select   (out_alu),
        .o_Store_Data   (store_data),
        .o_Pc           (out_pc),
        .o_Rd_Addr      (out_rd),
        .o_Reg_Write    (out_rw)
    );

    // Value the instruction would read for a source, given the bypasses now.
    function automatic logic [31:0] resolve(input logic [4:0] addr, input logic [31:0] rf);
        if (addr == 5'd0) return 32'd0;
        if (ex_valid && ex_rd == addr) return ex_data;
        if (wb_valid && wb_rd == addr) return wb_data;
        return rf;
    endfunction

    function automatic logic [31:0] pick_a(input logic [1:0] s, input logic [31:0] r1, input logic [31:0] p);
        if (s == 2'd0) return r1;
        if (s == 2'd1) return p;
        return 32'd0;
    endfunction

    function automatic logic [31:0] pick_b(input logic [1:0] s, input logic [31:0] r2, input logic [31:0] im);
        if (s == 2'd0) return r2;
        if (s == 2'd1) return im;
        if (s == 2'd2) return 32'd4;
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_a = 0; m_b = 0; m_st = 0; m_pc = 0;
        m_alu = ALU_OP_UNKNOWN; m_rd = 0; m_rw = 0;
        m_rs1 = 0; m_rs2 = 0; m_asel = 0; m_bsel = 0;
    endtask

    // Advances the model by one clock using the current inputs, then clocks.
    task automatic tick();
        logic accept;
        logic held;
        accept = !m_valid || down_ready;
        held   = m_valid && !down_ready;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (in_valid && accept && !flush) begin
                m_a    = pick_a(a_sel, resolve(rs1_addr, rs1_data), pc);
                m_b    = pick_b(b_sel, resolve(rs2_addr, rs2_data), imm);
                m_st   = resolve(rs2_addr, rs2_data);
                m_pc   = pc; m_alu = alu_sel; m_rd = rd_addr; m_rw = reg_write;
                m_rs1  = rs1_addr; m_rs2 = rs2_addr; m_asel = a_sel; m_bsel = b_sel;
            end else if (held && wb_valid) begin
                if (m_rs1 != 0 && wb_rd == m_rs1 && m_asel == 2'd0) m_a = wb_data;
                if (m_rs2 != 0 && wb_rd == m_rs2) begin
                    m_st = wb_data;
                    if (m_bsel == 2'd0) m_b = wb_data;
                end
            end
            if (flush) m_valid = 1'b0;
            else if (accept) m_valid = in_valid;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; pc = 0; rs1_addr = 0; rs2_addr = 0;
        rs1_data = 0; rs2_data = 0; imm = 0; a_sel = 0; b_sel = 0;
        alu_sel = ALU_OP_ADD; rd_addr = 0; reg_write = 0;
        ex_valid = 0; ex_rd = 0; ex_data = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
        down_ready = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0; in_valid = 1; pc = 32'h44; rs1_addr = 5'd3; rs1_data = 32'h5;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        checks++;
        if (op_a !== 32'd0 || op_b !== 32'd0 || store_data !== 32'd0 || out_pc !== 32'd0) begin
            errors++; $display("FAIL reset_data: a=%h b=%h st=%h pc=%h want all 0", op_a, op_b, store_data, out_pc);
        end
        checks++;
        if (out_alu !== ALU_OP_UNKNOWN) begin errors++; $display("FAIL reset_alu: got %h want %h", out_alu, ALU_OP_UNKNOWN); end
        rst_n = 1; idle_inputs();
        tick();
    endtask

    task automatic test_ex_priority();
        idle_inputs();
        in_valid = 1; rs1_addr = 5; rs1_data = 32'h11; a_sel = OP_A_RS1; b_sel = OP_B_IMM; imm = 32'h10;
        wb_valid = 1; wb_rd = 5; wb_data = 32'h22; ex_valid = 1; ex_rd = 5; ex_data = 32'h33;
        alu_sel = ALU_OP_SUB; rd_addr = 9; reg_write = 1;
        tick();
        checks++;
        if (op_a !== 32'h33) begin errors++; $display("FAIL ex_priority_a: got %h want 33", op_a); end
        checks++;
        if (op_b !== 32'h10 || out_valid !== 1'b1) begin errors++; $display("FAIL ex_priority_b: b=%h v=%0b want 10/1", op_b, out_valid); end
        checks++;
        if (out_alu !== ALU_OP_SUB || out_rd !== 5'd9 || out_rw !== 1'b1) begin
            errors++; $display("FAIL ex_priority_ctl: alu=%h rd=%0d rw=%0b want 1/9/1", out_alu, out_rd, out_rw);
        end
        ex_valid = 0;
        tick();
        checks++;
        if (op_a !== 32'h22) begin errors++; $display("FAIL wb_forward_a: got %h want 22", op_a); end
        idle_inputs();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %0b want 0", out_valid); end
    endtask

    task automatic test_x0();
        idle_inputs();
        in_valid = 1; rs1_addr = 0; rs1_data = 0; rs2_addr = 0; rs2_data = 0;
        ex_valid = 1; ex_rd = 0; ex_data = 32'hDEAD; wb_valid = 1; wb_rd = 0; wb_data = 32'hBEEF;
        a_sel = OP_A_RS1; b_sel = OP_B_RS2;
        tick();
        checks++;
        if (op_a !== 32'd0 || op_b !== 32'd0 || store_data !== 32'd0) begin
            errors++; $display("FAIL x0_forward: a=%h b=%h st=%h want 0", op_a, op_b, store_data);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_stall_snoop();
        idle_inputs();
        in_valid = 1; pc = 32'h100; rs1_addr = 3; rs1_data = 32'h5; rs2_addr = 7; rs2_data = 32'h1;
        a_sel = OP_A_RS1; b_sel = OP_B_RS2;
        tick();
        checks++;
        if (op_b !== 32'h1 || op_a !== 32'h5) begin errors++; $display("FAIL snoop_capture: a=%h b=%h want 5/1", op_a, op_b); end
        down_ready = 0; pc = 32'h200; rs2_data = 32'h77;
        ex_valid = 1; ex_rd = 7; ex_data = 32'h55;
        tick();
        checks++;
        if (op_b !== 32'h1 || out_pc !== 32'h100) begin errors++; $display("FAIL stall_ex_ignored: b=%h pc=%h want 1/100", op_b, out_pc); end
        ex_valid = 0; wb_valid = 1; wb_rd = 7; wb_data = 32'h99;
        tick();
        wb_valid = 0;
        checks++;
        if (op_b !== 32'h99 || store_data !== 32'h99) begin errors++; $display("FAIL stall_snoop: b=%h st=%h want 99/99", op_b, store_data); end
        checks++;
        if (out_valid !== 1'b1 || out_ready !== 1'b0 || op_a !== 32'h5) begin
            errors++; $display("FAIL stall_hold: v=%0b rdy=%0b a=%h want 1/0/5", out_valid, out_ready, op_a);
        end
        tick();
        checks++;
        if (op_b !== 32'h99 || out_pc !== 32'h100) begin errors++; $display("FAIL stall_keep: b=%h pc=%h want 99/100", op_b, out_pc); end
        down_ready = 1;
        #1;
        checks++;
        if (out_ready !== 1'b1) begin errors++; $display("FAIL handoff_ready: got %0b want 1", out_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200 || op_b !== 32'h77) begin
            errors++; $display("FAIL handoff_replace: v=%0b pc=%h b=%h want 1/200/77", out_valid, out_pc, op_b);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_pc_four();
        idle_inputs();
        in_valid = 1; pc = 32'h80; a_sel = OP_A_PC; b_sel = OP_B_FOUR;
        tick();
        checks++;
        if (op_a !== 32'h80 || op_b !== 32'd4) begin errors++; $display("FAIL pc_four: a=%h b=%h want 80/4", op_a, op_b); end
        a_sel = 2'd3; b_sel = 2'd3; rs1_addr = 2; rs1_data = 32'hAA; imm = 32'h12;
        tick();
        checks++;
        if (op_a !== 32'd0 || op_b !== 32'd0) begin errors++; $display("FAIL reserved_sel: a=%h b=%h want 0/0", op_a, op_b); end
        a_sel = OP_A_ZERO; b_sel = OP_B_IMM;
        tick();
        checks++;
        if (op_a !== 32'd0 || op_b !== 32'h12) begin errors++; $display("FAIL zero_imm: a=%h b=%h want 0/12", op_a, op_b); end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush();
        idle_inputs();
        in_valid = 1; pc = 32'h300; flush = 1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_block: got %0b want 0", out_valid); end
        flush = 0; pc = 32'h304;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h304) begin errors++; $display("FAIL after_flush: v=%0b pc=%h want 1/304", out_valid, out_pc); end
        down_ready = 0; flush = 1; pc = 32'h308;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0b want 0", out_valid); end
        flush = 0; down_ready = 1; pc = 32'h30C;
        tick();
        down_ready = 0; rst_n = 0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'd0) begin errors++; $display("FAIL reset_mid_stall: v=%0b pc=%h want 0/0", out_valid, out_pc); end
        rst_n = 1; idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        in_valid = 1; a_sel = OP_A_PC; b_sel = OP_B_IMM;
        for (int i = 0; i < 4; i++) begin
            pc = 32'h400 + 32'(i * 4); imm = 32'(i);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== pc || op_b !== imm) begin
                errors++; $display("FAIL back_to_back_%0d: v=%0b pc=%h b=%h want 1/%h/%h", i, out_valid, out_pc, op_b, pc, imm);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            flush      = ($urandom_range(0, 19) == 0);
            rst_n      = ($urandom_range(0, 99) != 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            down_ready = ($urandom_range(0, 2) != 0);
            pc = $urandom; imm = $urandom; rs1_data = $urandom; rs2_data = $urandom;
            rs1_addr = 5'($urandom_range(0, 3)); rs2_addr = 5'($urandom_range(0, 3));
            a_sel = 2'($urandom_range(0, 3)); b_sel = 2'($urandom_range(0, 3));
            alu_sel = 4'($urandom); rd_addr = 5'($urandom); reg_write = 1'($urandom);
            ex_valid = 1'($urandom); ex_rd = 5'($urandom_range(0, 3)); ex_data = $urandom;
            wb_valid = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
            #1;
            checks++;
            if (out_ready !== (!m_valid || down_ready)) begin
                errors++; $display("FAIL rand_ready@%0d: got %0b want %0b", n, out_ready, !m_valid || down_ready);
            end
            tick();
            checks++;
            if (out_valid !== m_valid) begin errors++; $display("FAIL rand_valid@%0d: got %0b want %0b", n, out_valid, m_valid); end
            if (m_valid) begin
                checks++;
                if (op_a !== m_a || op_b !== m_b || store_data !== m_st) begin
                    errors++; $display("FAIL rand_operands@%0d: a=%h b=%h st=%h want %h/%h/%h", n, op_a, op_b, store_data, m_a, m_b, m_st);
                end
                checks++;
                if (out_pc !== m_pc || out_alu !== m_alu || out_rd !== m_rd || out_rw !== m_rw) begin
                    errors++; $display("FAIL rand_ctl@%0d: pc=%h alu=%h rd=%0d rw=%0b want %h/%h/%0d/%0b", n, out_pc, out_alu, out_rd, out_rw, m_pc, m_alu, m_rd, m_rw);
                end
            end else if (!rst_n) begin
                checks++;
                if (op_a !== 32'd0 || out_alu !== ALU_OP_UNKNOWN) begin
                    errors++; $display("FAIL rand_reset@%0d: a=%h alu=%h want 0/%h", n, op_a, out_alu, ALU_OP_UNKNOWN);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rst_n = 0;
        #1;
        test_reset();
        test_ex_priority();
        test_x0();
        test_stall_snoop();
        test_pc_four();
        test_flush();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU: accepts a decoded instruction, resolves register hazards by forwarding, and registers the ALU operands (A/B) and ALU select.
- Keeps operands coherent while stalled by snooping writeback, so the ALU always sees correct inputs.
- Valid/ready handshake on both sides; the flush input comes from branch/jump resolution.

Parameters:
XLEN, 32, datapath width
REG_ADDR_WIDTH, 5, register address width

Ports:
i_Clock  in  1  clock
i_Reset_N  in  1  synchronous active-low reset
i_Flush  in  1  discard held and incoming instruction
i_Valid  in  1  decode presents instruction
o_Ready  out  1  stage can accept
i_Pc  in  XLEN  instruction PC
i_Rs1_Addr  in  REG_ADDR_WIDTH  source 1 index
i_Rs2_Addr  in  REG_ADDR_WIDTH  source 2 index
i_Rs1_Data  in  XLEN  regfile read 1
i_Rs2_Data  in  XLEN  regfile read 2
i_Immediate  in  XLEN  sign-extended immediate
i_Op_A_Sel  in  2  cpu.OP_A_RS1/OP_A_PC/OP_A_ZERO
i_Op_B_Sel  in  2  cpu.OP_B_RS2/OP_B_IMM/OP_B_FOUR
i_Alu_Select  in  4  cpu.ALU_OP_* code
i_Rd_Addr  in  REG_ADDR_WIDTH  destination
i_Reg_Write  in  1  writes rd
i_Fwd_Ex_Valid / i_Fwd_Ex_Rd / i_Fwd_Ex_Data  in  1/REG_ADDR_WIDTH/XLEN  EX/MEM result bypass
i_Fwd_Wb_Valid / i_Fwd_Wb_Rd / i_Fwd_Wb_Data  in  1/REG_ADDR_WIDTH/XLEN  MEM/WB writeback bypass
o_Valid  out  1  outputs hold an instruction
i_Ready  in  1  downstream accepts
o_Input_A / o_Input_B  out  XLEN  ALU operands
o_Alu_Select  out  4  to ALU
o_Store_Data  out  XLEN  forwarded rs2 (for stores)
o_Pc  out  XLEN  held PC
o_Rd_Addr  out  REG_ADDR_WIDTH  held destination
o_Reg_Write  out  1  held write enable

Behaviour:
- Reset (i_Reset_N=0 at posedge): o_Valid=0, every data output 0, o_Alu_Select=cpu.ALU_OP_UNKNOWN, stored rs addresses and selects 0.
- o_Ready = !o_Valid || i_Ready (combinational).
- Capture: when i_Valid && o_Ready, register the instruction at the next edge. Latency is 1 cycle; full throughput is back-to-back.
- When o_Valid && !i_Ready, all outputs hold, except operand snoop (below).
- When o_Valid && i_Ready && !i_Valid: o_Valid goes to 0 next cycle.
- Forward resolution per source (rs1, rs2) at capture: if addr==0, value is 0. Otherwise, priority is EX match (i_Fwd_Ex_Valid, rd==addr), then WB match, then regfile data.
- Operand A: RS1 gives the resolved rs1, PC gives i_Pc, ZERO gives 0.
- Operand B: RS2 gives the resolved rs2, IMM gives i_Immediate, FOUR gives 4.
- Reserved select code 3 yields 0.
- o_Store_Data always carries the resolved rs2.
- Snoop while stalled: if i_Fwd_Wb_Valid and i_Fwd_Wb_Rd equals the stored nonzero rs1 addr, update o_Input_A (only when the stored sel is RS1). Apply the same rule for rs2 to o_Input_B (only when sel is RS2) and to o_Store_Data (always). EX port is ignored during hold.
- Flush: i_Flush=1 forces o_Valid=0 next cycle and blocks same-cycle capture. Data outputs need not clear. Reset dominates flush.
- Simultaneous handoff and capture (o_Valid, i_Ready, i_Valid all 1): the new instruction replaces the old in one edge with no bubble.
- Reset asserted mid-stall drops the held instruction.

Decomposition:
- Package cpu holds OP_A_RS1=0, OP_A_PC=1, OP_A_ZERO=2, OP_B_RS2=0, OP_B_IMM=1, OP_B_FOUR=2, alongside the existing ALU_OP_* codes.
- One sub-module, operand_forward_mux: a combinational single-source resolver (addr, regfile data, EX/WB bypass in, value out), instantiated twice.

Test Plan:
- Reset: hold i_Reset_N=0 for 2 cycles with i_Valid=1 -> o_Valid=0, o_Input_A=0, o_Alu_Select=ALU_OP_UNKNOWN.
- EX-over-WB priority: rs1=5, regfile=0x11, WB rd=5 data=0x22, EX rd=5 data=0x33, sel RS1/IMM, imm=0x10 -> next cycle o_Input_A=0x33, o_Input_B=0x10.
- x0 never forwarded: rs1=0, EX rd=0 data=0xDEAD, i_Rs1_Data=0 -> o_Input_A=0.
- Stall snoop: capture rs2=7 (value 0x1), sel RS2. Hold i_Ready=0 for 3 cycles, in cycle 2 WB rd=7 data=0x99 -> o_Input_B=0x99, o_Store_Data=0x99, o_Valid stays 1, o_Ready=0.
- PC/FOUR: sel PC/FOUR, i_Pc=0x80 -> o_Input_A=0x80, o_Input_B=4.
- Flush vs capture: i_Flush=1 with i_Valid=1 and o_Ready=1 -> o_Valid=0 next cycle. The next clean instruction is captured normally.
